// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_queue
// Brief    : Instruction-fetch front end. Issues sequential fetches on a
//            valid/ready request port, keeps up to FBUF_DEPTH fetches in
//            flight or buffered, drops responses made stale by an EX redirect
//            and hands {pc, pc4, instr} to decode in program order.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_queue #(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FBUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_pc4,
   output logic [31:0]     out_instr
);

   localparam int              c_PW      = $clog2(FBUF_DEPTH);
   localparam int              c_CW      = c_PW + 1;
   localparam logic [c_CW:0]   c_DEPTH_X = (c_CW + 1)'(FBUF_DEPTH);
   localparam logic [XLEN-1:0] c_STEP    = XLEN'(4);

   logic [XLEN-1:0] r_fetch_pc;
   logic            r_run;       // low for the first cycle after reset
   logic [c_CW-1:0] r_inflight;
   logic [c_CW-1:0] r_drop;
   logic [c_CW-1:0] r_count;
   logic [c_PW-1:0] r_wp;
   logic [c_PW-1:0] r_rp;
   logic [c_PW-1:0] r_tag_wp;
   logic [c_PW-1:0] r_tag_rp;

   logic [XLEN-1:0] r_tag_mem   [FBUF_DEPTH];
   logic [XLEN-1:0] r_pc_mem    [FBUF_DEPTH];
   logic [31:0]     r_instr_mem [FBUF_DEPTH];

   logic w_credit;
   logic w_req_fire;
   logic w_rsp;
   logic w_rsp_keep;
   logic w_pop;

   // Request credit counts both outstanding fetches and buffered entries,
   // which is what keeps the response side free of any full stall.
   assign w_credit       = ({1'b0, r_inflight} + {1'b0, r_count}) < c_DEPTH_X;
   assign imem_req_valid = r_run && !redirect_valid && w_credit;
   assign imem_req_addr  = r_fetch_pc;
   assign w_req_fire     = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding can only be a leftover from before
   // reset, so it is ignored outright.
   assign w_rsp      = imem_rsp_valid && (r_inflight != '0);
   assign w_rsp_keep = w_rsp && (r_drop == '0) && !redirect_valid;

   assign out_valid = (r_count != '0);
   assign w_pop     = out_valid && out_ready && !redirect_valid;
   assign out_pc    = r_pc_mem[r_rp];
   assign out_pc4   = r_pc_mem[r_rp] + c_STEP;
   assign out_instr = r_instr_mem[r_rp];

   // Fetch PC, in-flight/drop accounting and all FIFO pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
         r_run      <= 1'b0;
         r_inflight <= '0;
         r_drop     <= '0;
         r_count    <= '0;
         r_wp       <= '0;
         r_rp       <= '0;
         r_tag_wp   <= '0;
         r_tag_rp   <= '0;
      end else begin
         r_run <= 1'b1;

         if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
         end else if (w_req_fire) begin
            r_fetch_pc <= r_fetch_pc + c_STEP;
         end

         // Tags track every outstanding request; dropped responses still
         // consume their tag, so the tag FIFO is never flushed.
         if (w_req_fire) begin
            r_tag_wp <= r_tag_wp + 1'b1;
         end
         if (w_rsp) begin
            r_tag_rp <= r_tag_rp + 1'b1;
         end

         r_inflight <= r_inflight + c_CW'(w_req_fire) - c_CW'(w_rsp);

         // Everything still outstanding after this cycle is stale.
         if (redirect_valid) begin
            r_drop <= r_inflight - c_CW'(w_rsp);
         end else if (w_rsp && (r_drop != '0)) begin
            r_drop <= r_drop - 1'b1;
         end

         if (redirect_valid) begin
            r_count <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
         end else begin
            if (w_rsp_keep) begin
               r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
               r_rp <= r_rp + 1'b1;
            end
            r_count <= r_count + c_CW'(w_rsp_keep) - c_CW'(w_pop);
         end
      end
   end

   // Storage arrays: contents are qualified by pointers, so no reset needed.
   always_ff @(posedge clk) begin
      if (w_req_fire) begin
         r_tag_mem[r_tag_wp] <= r_fetch_pc;
      end
      if (w_rsp_keep) begin
         r_pc_mem[r_wp]    <= r_tag_mem[r_tag_rp];
         r_instr_mem[r_wp] <= imem_rsp_data;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_queue
// Brief    : Directed self-checking bench for if_fetch_queue. Memory returns
//            instr = addr + 32'h1000_0000 after a selectable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_queue;

   localparam logic [31:0] OFS = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        req_valid;
   logic        req_ready = 1'b1;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_pc;
   logic [31:0] out_pc4;
   logic [31:0] out_instr;

   // second instance for the address wrap-around case
   logic        w2_redirect_valid = 1'b0;
   logic [31:0] w2_redirect_pc = '0;
   logic        w2_req_valid;
   logic        w2_req_ready = 1'b1;
   logic [31:0] w2_req_addr;
   logic        w2_rsp_valid;
   logic [31:0] w2_rsp_data;
   logic        w2_out_valid;
   logic        w2_out_ready = 1'b1;
   logic [31:0] w2_out_pc;
   logic [31:0] w2_out_pc4;
   logic [31:0] w2_out_instr;

   int total = 0;
   int bad   = 0;
   int lat   = 1;

   logic [3:0]  pv;
   logic [31:0] pa [4];
   logic        w2_pv;
   logic [31:0] w2_pa;

   always #5 clk = ~clk;

   if_fetch_queue #(.XLEN(32), .RESET_PC(32'h0), .FBUF_DEPTH(2)) u_dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
      .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_pc4(out_pc4), .out_instr(out_instr)
   );

   if_fetch_queue #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .FBUF_DEPTH(2)) u_wrap (
      .clk(clk), .rst(rst),
      .redirect_valid(w2_redirect_valid), .redirect_pc(w2_redirect_pc),
      .imem_req_valid(w2_req_valid), .imem_req_ready(w2_req_ready), .imem_req_addr(w2_req_addr),
      .imem_rsp_valid(w2_rsp_valid), .imem_rsp_data(w2_rsp_data),
      .out_valid(w2_out_valid), .out_ready(w2_out_ready),
      .out_pc(w2_out_pc), .out_pc4(w2_out_pc4), .out_instr(w2_out_instr)
   );

   // Fixed-latency in-order memory; latency 1..4 selected by lat.
   always @(posedge clk) begin
      if (rst) begin
         pv <= '0;
      end else begin
         pv    <= {pv[2:0], req_valid && req_ready};
         pa[0] <= req_addr;
         pa[1] <= pa[0];
         pa[2] <= pa[1];
         pa[3] <= pa[2];
      end
   end
   assign rsp_valid = pv[lat-1];
   assign rsp_data  = pa[lat-1] + OFS;

   // One-cycle memory for the wrap instance.
   always @(posedge clk) begin
      if (rst) begin
         w2_pv <= 1'b0;
      end else begin
         w2_pv <= w2_req_valid && w2_req_ready;
         w2_pa <= w2_req_addr;
      end
   end
   assign w2_rsp_valid = w2_pv;
   assign w2_rsp_data  = w2_pa + OFS;

   task automatic step;
      @(negedge clk);
      #1;
   endtask

   // Two reset edges; returns at the sample point of the first cycle after.
   task automatic do_reset;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      lat = 1; req_ready = 1'b1; out_ready = 1'b1;
      do_reset();
      total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b want=0", req_valid); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (req_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", req_addr); end
   endtask

   task automatic test_stream;
      int nf = 0;
      int np = 0;
      lat = 1; req_ready = 1'b0; out_ready = 1'b1;
      do_reset();
      repeat (3) begin
         step();
         total++; if (req_valid !== 1'b1 || req_addr !== 32'h0) begin
            bad++; $display("FAIL stall_hold got=%b/%h want=1/0", req_valid, req_addr);
         end
      end
      req_ready = 1'b1;
      #1;
      for (int c = 0; c < 40; c++) begin
         if (req_valid && req_ready && nf < 6) begin
            total++; if (req_addr !== 32'(nf * 4)) begin bad++; $display("FAIL stream_addr got=%h want=%h", req_addr, 32'(nf * 4)); end
            nf++;
         end
         if (out_valid && out_ready && np < 5) begin
            total++; if (out_pc !== 32'(np * 4)) begin bad++; $display("FAIL stream_pc got=%h want=%h", out_pc, 32'(np * 4)); end
            total++; if (out_pc4 !== 32'(np * 4 + 4)) begin bad++; $display("FAIL stream_pc4 got=%h want=%h", out_pc4, 32'(np * 4 + 4)); end
            total++; if (out_instr !== 32'(np * 4) + OFS) begin bad++; $display("FAIL stream_instr got=%h want=%h", out_instr, 32'(np * 4) + OFS); end
            np++;
         end
         if (nf >= 6 && np >= 5) break;
         step();
      end
      total++; if (nf < 6 || np < 5) begin bad++; $display("FAIL stream_timeout got=%0d/%0d want=6/5", nf, np); end
   endtask

   task automatic test_backpressure;
      int nf = 0;
      int np = 0;
      lat = 1; req_ready = 1'b1; out_ready = 1'b0;
      do_reset();
      repeat (10) begin
         step();
         if (req_valid && req_ready) nf++;
      end
      total++; if (nf != 2) begin bad++; $display("FAIL bp_req_count got=%0d want=2", nf); end
      total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL bp_req_valid got=%b want=0", req_valid); end
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin bad++; $display("FAIL bp_head got=%b/%h want=1/0", out_valid, out_pc); end
      out_ready = 1'b1;
      #1;
      for (int c = 0; c < 30; c++) begin
         if (out_valid && out_ready) begin
            total++; if (out_pc !== 32'(np * 4)) begin bad++; $display("FAIL bp_order got=%h want=%h", out_pc, 32'(np * 4)); end
            np++;
         end
         if (np >= 4) break;
         step();
      end
      total++; if (np < 4) begin bad++; $display("FAIL bp_timeout got=%0d want=4", np); end
   endtask

   task automatic test_redirect;
      int nf = 0;
      bit got_f = 0;
      bit got_p = 0;
      lat = 3; req_ready = 1'b1; out_ready = 1'b1;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         step();
         if (req_valid && req_ready) nf++;
         if (nf == 2 && !req_valid) break;
      end
      total++; if (nf != 2 || out_valid !== 1'b0) begin bad++; $display("FAIL redir_setup got=%0d/%b want=2/0", nf, out_valid); end
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      #1;
      total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL redir_req_gate got=%b want=0", req_valid); end
      step();
      redirect_valid = 1'b0;
      #1;
      for (int c = 0; c < 30; c++) begin
         if (req_valid && req_ready && !got_f) begin
            total++; if (req_addr !== 32'h100) begin bad++; $display("FAIL redir_addr got=%h want=100", req_addr); end
            got_f = 1;
         end
         if (out_valid && out_ready && !got_p) begin
            total++; if (out_pc !== 32'h100) begin bad++; $display("FAIL redir_pc got=%h want=100", out_pc); end
            total++; if (out_instr !== 32'h100 + OFS) begin bad++; $display("FAIL redir_instr got=%h want=%h", out_instr, 32'h100 + OFS); end
            got_p = 1;
         end
         if (got_f && got_p) break;
         step();
      end
      total++; if (!(got_f && got_p)) begin bad++; $display("FAIL redir_timeout got=%b%b want=11", got_f, got_p); end
   endtask

   task automatic test_redirect_rsp;
      bit found = 0;
      bit got_p = 0;
      lat = 1; req_ready = 1'b1; out_ready = 1'b1;
      do_reset();
      for (int c = 0; c < 20; c++) begin
         step();
         if (rsp_valid && out_valid) begin found = 1; break; end
      end
      total++; if (!found) begin bad++; $display("FAIL rr_setup got=0 want=1"); end
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      #1;
      total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL rr_req_gate got=%b want=0", req_valid); end
      step();
      redirect_valid = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rr_flush got=%b want=0", out_valid); end
      total++; if (req_valid !== 1'b1 || req_addr !== 32'h200) begin bad++; $display("FAIL rr_next_req got=%b/%h want=1/200", req_valid, req_addr); end
      for (int c = 0; c < 20; c++) begin
         step();
         if (out_valid) begin
            total++; if (out_pc !== 32'h200) begin bad++; $display("FAIL rr_first_pc got=%h want=200", out_pc); end
            got_p = 1;
            break;
         end
      end
      total++; if (!got_p) begin bad++; $display("FAIL rr_timeout got=0 want=1"); end
   endtask

   task automatic test_wrap;
      logic [31:0] ea [3];
      logic [31:0] e4 [3];
      int nf = 0;
      int np = 0;
      ea[0] = 32'hFFFF_FFF8; ea[1] = 32'hFFFF_FFFC; ea[2] = 32'h0000_0000;
      e4[0] = 32'hFFFF_FFFC; e4[1] = 32'h0000_0000; e4[2] = 32'h0000_0004;
      do_reset();
      for (int c = 0; c < 20; c++) begin
         if (w2_req_valid && w2_req_ready && nf < 3) begin
            total++; if (w2_req_addr !== ea[nf]) begin bad++; $display("FAIL wrap_addr got=%h want=%h", w2_req_addr, ea[nf]); end
            nf++;
         end
         if (w2_out_valid && w2_out_ready && np < 3) begin
            total++; if (w2_out_pc !== ea[np]) begin bad++; $display("FAIL wrap_pc got=%h want=%h", w2_out_pc, ea[np]); end
            total++; if (w2_out_pc4 !== e4[np]) begin bad++; $display("FAIL wrap_pc4 got=%h want=%h", w2_out_pc4, e4[np]); end
            np++;
         end
         if (nf >= 3 && np >= 3) break;
         step();
      end
      total++; if (nf < 3 || np < 3) begin bad++; $display("FAIL wrap_timeout got=%0d/%0d want=3/3", nf, np); end
   endtask

   task automatic test_reset_mid;
      bit found = 0;
      bit got_f = 0;
      bit got_p = 0;
      lat = 2; req_ready = 1'b1; out_ready = 1'b0;
      do_reset();
      for (int c = 0; c < 20; c++) begin
         step();
         if (out_valid) begin found = 1; break; end
      end
      total++; if (!found || rsp_valid !== 1'b1) begin bad++; $display("FAIL rm_setup got=%b/%b want=1/1", found, rsp_valid); end
      rst = 1'b1;
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_out_valid got=%b want=0", out_valid); end
      total++; if (req_valid !== 1'b0 || req_addr !== 32'h0) begin bad++; $display("FAIL rm_req got=%b/%h want=0/0", req_valid, req_addr); end
      rst = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         step();
         if (req_valid && req_ready && !got_f) begin
            total++; if (req_addr !== 32'h0) begin bad++; $display("FAIL rm_restart_addr got=%h want=0", req_addr); end
            got_f = 1;
         end
         if (out_valid && !got_p) begin
            total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL rm_first_pc got=%h want=0", out_pc); end
            got_p = 1;
         end
         if (got_f && got_p) break;
      end
      total++; if (!(got_f && got_p)) begin bad++; $display("FAIL rm_timeout got=%b%b want=11", got_f, got_p); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_redirect_rsp();
      test_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
